// File: rtl/sync_mux_pkg.sv
// Shared types and helpers for the sync_mux_scan block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//   state_t      : switch FSM states (hold a channel / blank during a switch)
//   sel_w()      : select width for a given channel count, never below 1
//   next_channel : next enabled channel above cur, wrapping; returns cur if none
package sync_mux_pkg;

  localparam int MAX_CH = 16;

  typedef enum logic {
    ST_HOLD  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  function automatic int sel_w(input int n_ch);
    return (n_ch <= 2) ? 1 : $clog2(n_ch);
  endfunction

  // Loop runs from the far end down so the nearest enabled channel
  // above cur is the last assignment and wins.
  function automatic int next_channel(input int cur, input int n_ch,
                                      input logic [MAX_CH-1:0] mask);
    int nxt;
    int idx;
    nxt = cur;
    for (int i = MAX_CH - 1; i >= 1; i--) begin
      if (i < n_ch) begin
        idx = (cur + i) % n_ch;
        if (mask[idx]) nxt = idx;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sync_mux_dwell_timer.sv
// Dwell timer: counts enabled cycles and flags the last cycle of each dwell period.
// Latency: tc is combinational from the count; the count updates on the next edge.
// Backpressure: none; ena=0 freezes the count.
//   clk, rst_n : clock, async active-low reset
//   ena        : global clock enable
//   cnt_en     : count this cycle (holding a channel in scan mode)
//   clr        : force the count back to 0 (takes priority over cnt_en)
//   tc         : high on the cycle the count sits at DWELL-1 while counting
module sync_mux_dwell_timer #(
  parameter int DWELL = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic cnt_en,
  input  logic clr,
  output logic tc
);

  localparam int CW = (DWELL <= 2) ? 1 : $clog2(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  assign tc = cnt_en && (cnt == LAST);

  // Wrap at the terminal count so a scan step that finds no other channel
  // simply starts a fresh dwell period instead of sticking at DWELL-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena) begin
      if (clr)         cnt <= '0;
      else if (cnt_en) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sync_mux_scan.sv
// N-channel registered mux with break-before-make blanking and auto-scan.
// Latency: dout follows din[cur_sel] one cycle later; a switch blanks dout for BLANK cycles.
// Backpressure: none; ena=0 freezes all state, bad sel_load requests are dropped with sel_err.
//   din      : N_CH*WIDTH channel data, channel k = din[k*WIDTH +: WIDTH]
//   sel_in   : requested channel, loaded by the sel_load strobe (manual mode)
//   scan_en  : 1 = rotate channels every DWELL held cycles
//   dout     : registered selected data   cur_sel : channel driving dout
//   busy     : high while blanking         sel_err : one-cycle pulse on a rejected request
// Optional macro SYNC_MUX_CH_MASK_EN adds ch_mask[N_CH] (1 = channel usable).
module sync_mux_scan
  import sync_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 1,
  parameter  int DWELL = 8,
  parameter  int BLANK = 1,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [N_CH*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic                  sel_load,
  input  logic                  scan_en,
`ifdef SYNC_MUX_CH_MASK_EN
  input  logic [N_CH-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]      dout,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  busy,
  output logic                  sel_err
);

  localparam int BW = (BLANK <= 2) ? 1 : $clog2(BLANK);
  localparam logic [BW-1:0] BLANK_LOAD = (BLANK > 0) ? BW'(BLANK - 1) : '0;

  state_t            state, state_nxt;
  logic [BW-1:0]     blank_cnt, blank_nxt;
  logic [SEL_W-1:0]  tgt, tgt_nxt, sel_nxt;
  logic [WIDTH-1:0]  dout_nxt;
  logic [MAX_CH-1:0] mask16;
  logic              sel_in_ok;
  logic [SEL_W-1:0]  scan_tgt, switch_tgt;
  logic              manual_evt, scan_evt, scan_tc, completion;

  always_comb begin
    mask16 = '0;
`ifdef SYNC_MUX_CH_MASK_EN
    mask16[N_CH-1:0] = ch_mask;
`else
    mask16[N_CH-1:0] = '1;
`endif
  end

  // A request is usable only if it names an existing, unmasked channel.
  assign sel_in_ok  = (int'(sel_in) < N_CH) && mask16[sel_in];
  assign scan_tgt   = SEL_W'(next_channel(int'(cur_sel), N_CH, mask16));
  assign manual_evt = !scan_en && sel_load && sel_in_ok && (sel_in != cur_sel);
  assign scan_evt   = scan_en && scan_tc && (scan_tgt != cur_sel);
  assign switch_tgt = scan_en ? scan_tgt : sel_in;
  assign busy       = (state == ST_BLANK);

  sync_mux_dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .cnt_en (scan_en && (state == ST_HOLD)),
    .clr    (!scan_en || completion),
    .tc     (scan_tc)
  );

  always_comb begin
    state_nxt  = state;
    blank_nxt  = blank_cnt;
    tgt_nxt    = tgt;
    sel_nxt    = cur_sel;
    dout_nxt   = dout;
    completion = 1'b0;
    case (state)
      ST_HOLD: begin
        dout_nxt = din[int'(cur_sel)*WIDTH +: WIDTH];
        if (manual_evt || scan_evt) begin
          if (BLANK > 0) begin
            state_nxt = ST_BLANK;
            blank_nxt = BLANK_LOAD;
            tgt_nxt   = switch_tgt;
          end else begin
            sel_nxt    = switch_tgt;
            completion = 1'b1;
          end
        end
      end
      ST_BLANK: begin
        // sel_load is ignored here; the in-flight switch always completes.
        dout_nxt = '0;
        if (blank_cnt == '0) begin
          sel_nxt    = tgt;
          state_nxt  = ST_HOLD;
          completion = 1'b1;
        end else begin
          blank_nxt = blank_cnt - 1'b1;
        end
      end
      default: state_nxt = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HOLD;
      blank_cnt <= '0;
      tgt       <= '0;
      cur_sel   <= '0;
      dout      <= '0;
    end else if (ena) begin
      state     <= state_nxt;
      blank_cnt <= blank_nxt;
      tgt       <= tgt_nxt;
      cur_sel   <= sel_nxt;
      dout      <= dout_nxt;
    end
  end

  // Error pulse is reported in any state or mode; it never survives a frozen cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   sel_err <= 1'b0;
    else if (ena) sel_err <= sel_load && !sel_in_ok;
    else          sel_err <= 1'b0;
  end

endmodule

// File: tb/tb_sync_mux_scan.sv
// Bench for sync_mux_scan: directed steps then random stimulus against a reference model.
// Two instances: N_CH=4 and N_CH=3 (the latter exposes out-of-range requests).
// Build with +define+SYNC_MUX_CH_MASK_EN to also exercise channel masking.
module tb_sync_mux_scan;

  localparam int DWELL_P = 3;
  localparam int BLANK_P = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] din4 = '0;
  logic [1:0] sel_in = '0;
  logic       sel_load = 1'b0;
  logic       scan_en = 1'b0;
  logic [3:0] ch_mask4 = 4'b1111;

  logic [1:0] d4_dout, d4_cur_sel, d3_dout, d3_cur_sel;
  logic       d4_busy, d4_err, d3_busy, d3_err;

  always #5 clk = ~clk;

  sync_mux_scan #(.N_CH(4), .WIDTH(2), .DWELL(DWELL_P), .BLANK(BLANK_P)) u_d4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .din(din4), .sel_in(sel_in),
    .sel_load(sel_load), .scan_en(scan_en),
`ifdef SYNC_MUX_CH_MASK_EN
    .ch_mask(ch_mask4),
`endif
    .dout(d4_dout), .cur_sel(d4_cur_sel), .busy(d4_busy), .sel_err(d4_err)
  );

  sync_mux_scan #(.N_CH(3), .WIDTH(2), .DWELL(DWELL_P), .BLANK(BLANK_P)) u_d3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .din(din4[5:0]), .sel_in(sel_in),
    .sel_load(sel_load), .scan_en(scan_en),
`ifdef SYNC_MUX_CH_MASK_EN
    .ch_mask(ch_mask4[2:0]),
`endif
    .dout(d3_dout), .cur_sel(d3_cur_sel), .busy(d3_busy), .sel_err(d3_err)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: one entry per instance (0 -> N_CH=4, 1 -> N_CH=3).
  int nch[2] = '{4, 3};
  int m_sel[2], m_tgt[2], m_left[2], m_age[2], m_dout[2];
  bit m_busy[2], m_err[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit ch_ok(input int i, input int c);
    return (c < nch[i]) && ch_mask4[c];
  endfunction

  function automatic int chval(input int c);
    return int'((din4 >> (2 * c)) & 8'h3);
  endfunction

  function automatic int next_en(input int i);
    for (int d = 1; d < nch[i]; d++) begin
      if (ch_ok(i, (m_sel[i] + d) % nch[i])) return (m_sel[i] + d) % nch[i];
    end
    return m_sel[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sel[i] = 0; m_tgt[i] = 0; m_left[i] = 0; m_age[i] = 0;
      m_dout[i] = 0; m_busy[i] = 0; m_err[i] = 0;
    end
  endtask

  // One rising edge of behaviour, using the inputs currently applied.
  task automatic model_step();
    int t, nd;
    bit err;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (!ena) begin
        m_err[i] = 0;
        continue;
      end
      err = sel_load && !ch_ok(i, int'(sel_in));
      nd  = m_busy[i] ? 0 : chval(m_sel[i]);
      t   = -1;
      if (m_busy[i]) begin
        if (m_left[i] == 0) begin
          m_sel[i] = m_tgt[i]; m_busy[i] = 0; m_age[i] = 0;
        end else begin
          m_left[i]--;
        end
        if (!scan_en) m_age[i] = 0;
      end else if (scan_en) begin
        if (m_age[i] == DWELL_P - 1) begin
          m_age[i] = 0;
          t = next_en(i);
          if (t == m_sel[i]) t = -1;
        end else begin
          m_age[i]++;
        end
      end else begin
        m_age[i] = 0;
        if (sel_load && !err && int'(sel_in) != m_sel[i]) t = int'(sel_in);
      end
      if (t >= 0) begin
        if (BLANK_P > 0) begin
          m_busy[i] = 1; m_left[i] = BLANK_P - 1; m_tgt[i] = t;
        end else begin
          m_sel[i] = t; m_age[i] = 0;
        end
      end
      m_err[i]  = err;
      m_dout[i] = nd;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("d4_dout", 32'(d4_dout), 32'(m_dout[0]));
    chk("d4_cur_sel", 32'(d4_cur_sel), 32'(m_sel[0]));
    chk("d4_busy", 32'(d4_busy), 32'(m_busy[0]));
    chk("d4_sel_err", 32'(d4_err), 32'(m_err[0]));
    chk("d3_dout", 32'(d3_dout), 32'(m_dout[1]));
    chk("d3_cur_sel", 32'(d3_cur_sel), 32'(m_sel[1]));
    chk("d3_busy", 32'(d3_busy), 32'(m_busy[1]));
    chk("d3_sel_err", 32'(d3_err), 32'(m_err[1]));
  endtask

  // Steps until d4 shows channel v; checks it arrives after exactly 4 cycles.
  task automatic expect_scan_to(input string tag, input int v);
    int cnt = 0;
    bit found = 0;
    while (cnt < 10 && !found) begin
      step();
      cnt++;
      if (int'(d4_cur_sel) == v) found = 1;
    end
    chk({tag, "_reached"}, 32'(found), 32'd1);
    chk({tag, "_period"}, 32'(cnt), 32'd4);
  endtask

  initial begin
    int cnt;
    bit found;
    int vis[4];

    // Reset state
    din4 = 8'b00_11_10_01;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_dout", 32'(d4_dout), 32'd0);
    chk("rst_cur_sel", 32'(d4_cur_sel), 32'd0);
    chk("rst_busy", 32'(d4_busy), 32'd0);
    chk("rst_sel_err", 32'(d4_err), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // First data after reset: channel 0, one cycle latency
    step();
    chk("t1_dout", 32'(d4_dout), 32'd1);
    chk("t1_cur_sel", 32'(d4_cur_sel), 32'd0);
    chk("t1_busy", 32'(d4_busy), 32'd0);

    // Manual switch to channel 2 with one blank cycle
    sel_in = 2'd2; sel_load = 1'b1;
    step();
    chk("t2_busy", 32'(d4_busy), 32'd1);
    sel_load = 1'b0;
    step();
    chk("t2_blank_dout", 32'(d4_dout), 32'd0);
    chk("t2_cur_sel", 32'(d4_cur_sel), 32'd2);
    step();
    chk("t2_new_dout", 32'(d4_dout), 32'd3);

    // Out-of-range on the 3-channel instance
    sel_in = 2'd3; sel_load = 1'b1;
    step();
    chk("t3_err", 32'(d3_err), 32'd1);
    chk("t3_cur_sel", 32'(d3_cur_sel), 32'd2);
    chk("t3_dout", 32'(d3_dout), 32'd3);
    sel_load = 1'b0;
    step();
    chk("t3_err_clear", 32'(d3_err), 32'd0);

    // Back to channel 0, then scan 0->1->2->3->0
    sel_in = 2'd0; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    repeat (3) step();
    din4 = 8'b10_11_10_01;
    scan_en = 1'b1;
    vis = '{1, 2, 3, 0};
    foreach (vis[k]) expect_scan_to($sformatf("t4_scan%0d", k), vis[k]);

    // Asynchronous reset while blanking
    cnt = 0; found = 0;
    while (cnt < 8 && !found) begin
      step();
      cnt++;
      if (d4_busy) found = 1;
    end
    chk("t5_busy_seen", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_dout", 32'(d4_dout), 32'd0);
    chk("t5_cur_sel", 32'(d4_cur_sel), 32'd0);
    chk("t5_busy", 32'(d4_busy), 32'd0);
    model_reset();
    step();
    rst_n = 1'b1;
    scan_en = 1'b0;
    step();

`ifdef SYNC_MUX_CH_MASK_EN
    // Masked scan 0->1->3->1->3 and a rejected masked request
    ch_mask4 = 4'b1010;
    scan_en = 1'b1;
    vis = '{1, 3, 1, 3};
    foreach (vis[k]) expect_scan_to($sformatf("t6_scan%0d", k), vis[k]);
    scan_en = 1'b0;
    repeat (2) step();
    sel_in = 2'd2; sel_load = 1'b1;
    step();
    chk("t6_err", 32'(d4_err), 32'd1);
    chk("t6_busy", 32'(d4_busy), 32'd0);
    sel_load = 1'b0;
    step();
    chk("t6_err_clear", 32'(d4_err), 32'd0);
    ch_mask4 = 4'b1111;
`endif

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      din4     = 8'($urandom);
      sel_in   = 2'($urandom);
      sel_load = ($urandom_range(0, 3) == 0);
      ena      = ($urandom_range(0, 7) != 0);
      rst_n    = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 19) == 0) scan_en = ~scan_en;
`ifdef SYNC_MUX_CH_MASK_EN
      if ($urandom_range(0, 49) == 0) ch_mask4 = 4'($urandom);
`endif
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
